// File: rtl/bcd_seq_converter.sv
// -----------------------------------------------------------------------------
// bcd_seq_converter
//
// Sequential binary-to-BCD converter using shift-and-add-3 (double dabble).
// One operand bit is consumed per clock, so a conversion takes WIDTH cycles.
// Bits carried out of the top BCD digit are OR-ed into an overflow flag.
// Because the digit adjust never looks at higher digits, the low DIGITS
// digits stay exact even when the operand does not fit.
//
// Parameters:
//   WIDTH   binary operand width (>= 1)
//   DIGITS  number of BCD digits produced (>= 1)
//
// Ports:
//   clk      in   rising-edge clock
//   rst_n    in   asynchronous active-low reset
//   start    in   request a conversion of bin_in (ignored while busy)
//   bin_in   in   unsigned operand, sampled when start is accepted
//   busy     out  conversion in progress
//   done     out  one-cycle pulse; bcd_out and ovf were just updated
//   bcd_out  out  packed BCD result, units digit in [3:0]
//   ovf      out  last operand was >= 10**DIGITS
// -----------------------------------------------------------------------------
module bcd_seq_converter #(
    parameter int WIDTH  = 6,
    parameter int DIGITS = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin_in,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  ovf
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t             state_reg,     state_next;
    logic [WIDTH-1:0]   bin_shift_reg, bin_shift_next;
    logic [BCD_W-1:0]   bcd_work_reg,  bcd_work_next;
    logic               ovf_acc_reg,   ovf_acc_next;
    logic [CNT_W-1:0]   cnt_reg,       cnt_next;
    logic [BCD_W-1:0]   bcd_out_reg,   bcd_out_next;
    logic               ovf_reg,       ovf_next;
    logic               done_reg,      done_next;

    // Adjusted digits: every digit >= 5 gets +3 before the shift so that the
    // doubling produces a correct decimal carry into the next digit.
    logic [BCD_W-1:0]   bcd_adj;
    logic [BCD_W-1:0]   bcd_shifted;
    logic               carry_out;
    logic               last_shift;

    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adjust
            assign bcd_adj[4*gi +: 4] = (bcd_work_reg[4*gi +: 4] >= 4'd5)
                                      ? bcd_work_reg[4*gi +: 4] + 4'd3
                                      : bcd_work_reg[4*gi +: 4];
        end
    endgenerate

    // Shift {bcd_adj, bin_shift} left by one: operand MSB enters units LSB,
    // the top BCD bit falls out as the overflow carry.
    assign carry_out   = bcd_adj[BCD_W-1];
    assign bcd_shifted = {bcd_adj[BCD_W-2:0], bin_shift_reg[WIDTH-1]};
    assign last_shift  = (cnt_reg == CNT_W'(1));

    // ---------------------------------------------------------------- state reg
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            bin_shift_reg <= '0;
            bcd_work_reg  <= '0;
            ovf_acc_reg   <= 1'b0;
            cnt_reg       <= '0;
            bcd_out_reg   <= '0;
            ovf_reg       <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            bin_shift_reg <= bin_shift_next;
            bcd_work_reg  <= bcd_work_next;
            ovf_acc_reg   <= ovf_acc_next;
            cnt_reg       <= cnt_next;
            bcd_out_reg   <= bcd_out_next;
            ovf_reg       <= ovf_next;
            done_reg      <= done_next;
        end
    end

    // ---------------------------------------------------- next-state / datapath
    always_comb begin
        state_next     = state_reg;
        bin_shift_next = bin_shift_reg;
        bcd_work_next  = bcd_work_reg;
        ovf_acc_next   = ovf_acc_reg;
        cnt_next       = cnt_reg;
        bcd_out_next   = bcd_out_reg;
        ovf_next       = ovf_reg;
        done_next      = 1'b0;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next     = SHIFT;
                    bin_shift_next = bin_in;
                    bcd_work_next  = '0;
                    ovf_acc_next   = 1'b0;
                    cnt_next       = CNT_W'(WIDTH);
                end
            end
            SHIFT: begin
                bin_shift_next = bin_shift_reg << 1;
                bcd_work_next  = bcd_shifted;
                ovf_acc_next   = ovf_acc_reg | carry_out;
                cnt_next       = cnt_reg - CNT_W'(1);
                if (last_shift) begin
                    // Publish the post-shift value, including this cycle's carry.
                    state_next   = IDLE;
                    bcd_out_next = bcd_shifted;
                    ovf_next     = ovf_acc_reg | carry_out;
                    done_next    = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------ outputs
    always_comb begin
        busy    = (state_reg == SHIFT);
        done    = done_reg;
        bcd_out = bcd_out_reg;
        ovf     = ovf_reg;
    end

endmodule

// File: tb/tb_bcd_seq_converter.sv
module tb_bcd_seq_converter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    // Instance 0: WIDTH=6 DIGITS=2, instance 1: WIDTH=8 DIGITS=2,
    // instance 2: WIDTH=8 DIGITS=3.
    logic        start_a = 1'b0, start_b = 1'b0, start_c = 1'b0;
    logic [5:0]  bin_a = '0;
    logic [7:0]  bin_b = '0, bin_c = '0;
    logic        busy_a, busy_b, busy_c;
    logic        done_a, done_b, done_c;
    logic [7:0]  bcd_a, bcd_b;
    logic [11:0] bcd_c;
    logic        ovf_a, ovf_b, ovf_c;

    bcd_seq_converter #(.WIDTH(6), .DIGITS(2)) u_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .bin_in(bin_a),
        .busy(busy_a), .done(done_a), .bcd_out(bcd_a), .ovf(ovf_a));
    bcd_seq_converter #(.WIDTH(8), .DIGITS(2)) u_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .bin_in(bin_b),
        .busy(busy_b), .done(done_b), .bcd_out(bcd_b), .ovf(ovf_b));
    bcd_seq_converter #(.WIDTH(8), .DIGITS(3)) u_c (
        .clk(clk), .rst_n(rst_n), .start(start_c), .bin_in(bin_c),
        .busy(busy_c), .done(done_c), .bcd_out(bcd_c), .ovf(ovf_c));

    // ------------------------------------------------------------ ref model
    function automatic int width_of(input int sel);
        return (sel == 0) ? 6 : 8;
    endfunction

    function automatic int digits_of(input int sel);
        return (sel == 2) ? 3 : 2;
    endfunction

    function automatic int pow10(input int d);
        int p = 1;
        for (int i = 0; i < d; i++) p = p * 10;
        return p;
    endfunction

    function automatic logic [11:0] ref_bcd(input int v, input int d);
        logic [11:0] r = '0;
        int m = v % pow10(d);
        for (int i = 0; i < d; i++) begin
            r[4*i +: 4] = 4'(m % 10);
            m = m / 10;
        end
        return r;
    endfunction

    function automatic logic ref_ovf(input int v, input int d);
        return v >= pow10(d);
    endfunction

    // ------------------------------------------------------------ DUT access
    task automatic set_in(input int sel, input logic s, input int v);
        case (sel)
            0: begin start_a = s; bin_a = 6'(v); end
            1: begin start_b = s; bin_b = 8'(v); end
            default: begin start_c = s; bin_c = 8'(v); end
        endcase
    endtask

    function automatic logic get_done(input int sel);
        case (sel)
            0: return done_a;
            1: return done_b;
            default: return done_c;
        endcase
    endfunction

    function automatic logic get_busy(input int sel);
        case (sel)
            0: return busy_a;
            1: return busy_b;
            default: return busy_c;
        endcase
    endfunction

    function automatic logic [11:0] get_bcd(input int sel);
        case (sel)
            0: return {4'h0, bcd_a};
            1: return {4'h0, bcd_b};
            default: return bcd_c;
        endcase
    endfunction

    function automatic logic get_ovf(input int sel);
        case (sel)
            0: return ovf_a;
            1: return ovf_b;
            default: return ovf_c;
        endcase
    endfunction

    // One start pulse, then wait (bounded) for done. lat = -1 on timeout.
    task automatic do_conv(input int sel, input int v,
                           output logic [11:0] bcd, output logic ov, output int lat);
        @(negedge clk);
        set_in(sel, 1'b1, v);
        @(posedge clk);
        #1;
        set_in(sel, 1'b0, v);
        lat = -1;
        bcd = 'x;
        ov  = 1'bx;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (get_done(sel)) begin
                lat = i;
                bcd = get_bcd(sel);
                ov  = get_ovf(sel);
                break;
            end
        end
        $display("conv dut=%0d in=%0d bcd=%h ovf=%b lat=%0d", sel, v, bcd, ov, lat);
    endtask

    // ------------------------------------------------------------ tests
    task automatic test_reset();
        @(posedge clk);
        #1;
        total++;
        if ({busy_a, done_a, bcd_a, ovf_a} !== 11'd0) begin
            bad++;
            $display("FAIL reset_a: got busy=%b done=%b bcd=%h ovf=%b want all 0",
                     busy_a, done_a, bcd_a, ovf_a);
        end
        total++;
        if ({busy_c, done_c, bcd_c, ovf_c} !== 15'd0) begin
            bad++;
            $display("FAIL reset_c: got busy=%b done=%b bcd=%h ovf=%b want all 0",
                     busy_c, done_c, bcd_c, ovf_c);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic check_conv(input string name, input int sel, input int v);
        logic [11:0] bcd;
        logic        ov;
        int          lat;
        do_conv(sel, v, bcd, ov, lat);
        total++;
        if (bcd !== ref_bcd(v, digits_of(sel))) begin
            bad++;
            $display("FAIL %s_bcd: in=%0d got %h want %h", name, v, bcd, ref_bcd(v, digits_of(sel)));
        end
        total++;
        if (ov !== ref_ovf(v, digits_of(sel))) begin
            bad++;
            $display("FAIL %s_ovf: in=%0d got %b want %b", name, v, ov, ref_ovf(v, digits_of(sel)));
        end
        total++;
        if (lat != width_of(sel)) begin
            bad++;
            $display("FAIL %s_lat: in=%0d got %0d want %0d", name, v, lat, width_of(sel));
        end
    endtask

    task automatic test_exhaustive();
        for (int v = 0; v < 64; v++) check_conv("exh", 0, v);
    endtask

    task automatic test_overflow();
        check_conv("ovf", 1, 99);
        check_conv("ovf", 1, 100);
        check_conv("ovf", 1, 255);
    endtask

    task automatic test_width();
        check_conv("wid", 2, 255);
        check_conv("wid", 2, 128);
        check_conv("wid", 2, 0);
    endtask

    task automatic test_random();
        for (int k = 0; k < 60; k++) begin
            int sel = k % 3;
            int v   = int'($urandom_range((1 << width_of(sel)) - 1, 0));
            check_conv("rnd", sel, v);
        end
    endtask

    task automatic test_handshake();
        int          ndone = 0;
        logic [11:0] got = 'x;
        @(negedge clk);
        set_in(0, 1'b1, 37);
        @(posedge clk);              // E0
        #1;
        set_in(0, 1'b0, 37);
        @(posedge clk);              // E1
        @(negedge clk);
        set_in(0, 1'b1, 12);         // ignored: converter is busy
        total++;
        if (busy_a !== 1'b1) begin
            bad++;
            $display("FAIL hs_busy: got %b want 1", busy_a);
        end
        @(posedge clk);
        #1;
        set_in(0, 1'b0, 12);
        for (int i = 0; i < 14; i++) begin
            @(posedge clk);
            #1;
            if (done_a) begin
                ndone++;
                got = {4'h0, bcd_a};
            end
        end
        $display("handshake dones=%0d bcd=%h", ndone, got);
        total++;
        if (ndone != 1) begin
            bad++;
            $display("FAIL hs_ndone: got %0d want 1", ndone);
        end
        total++;
        if (got !== 12'h037) begin
            bad++;
            $display("FAIL hs_bcd: got %h want 037", got);
        end
    endtask

    task automatic test_back_to_back();
        int c1 = -1, c2 = -1;
        logic [11:0] got = 'x;
        @(negedge clk);
        set_in(0, 1'b1, 12);
        for (int i = 0; i < 40 && c2 < 0; i++) begin
            @(posedge clk);
            #1;
            if (done_a) begin
                if (c1 < 0) c1 = cyc;
                else begin
                    c2  = cyc;
                    got = {4'h0, bcd_a};
                end
            end
        end
        @(negedge clk);
        set_in(0, 1'b0, 12);
        $display("back_to_back first=%0d second=%0d bcd=%h", c1, c2, got);
        total++;
        if (c1 < 0 || c2 < 0 || c2 - c1 != 7) begin
            bad++;
            $display("FAIL b2b_gap: got %0d want 7", c2 - c1);
        end
        total++;
        if (got !== 12'h012) begin
            bad++;
            $display("FAIL b2b_bcd: got %h want 012", got);
        end
        @(posedge clk);
        #1;
        total++;
        if (busy_a !== 1'b0) begin
            bad++;
            $display("FAIL b2b_idle: busy got %b want 0", busy_a);
        end
    endtask

    task automatic test_reset_mid();
        int ndone = 0;
        @(negedge clk);
        set_in(0, 1'b1, 50);
        @(posedge clk);              // E0
        #1;
        set_in(0, 1'b0, 50);
        @(posedge clk);
        @(posedge clk);
        #2;
        total++;
        if (busy_a !== 1'b1) begin
            bad++;
            $display("FAIL rst_pre_busy: got %b want 1", busy_a);
        end
        rst_n = 1'b0;
        #1;
        $display("reset_mid busy=%b done=%b bcd=%h ovf=%b", busy_a, done_a, bcd_a, ovf_a);
        total++;
        if ({busy_a, done_a, bcd_a, ovf_a} !== 11'd0) begin
            bad++;
            $display("FAIL rst_mid: got busy=%b done=%b bcd=%h ovf=%b want all 0",
                     busy_a, done_a, bcd_a, ovf_a);
        end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (done_a) ndone++;
        end
        total++;
        if (ndone != 0) begin
            bad++;
            $display("FAIL rst_no_done: got %0d dones want 0", ndone);
        end
        check_conv("rst_after", 0, 21);
    endtask

    initial begin
        test_reset();
        test_exhaustive();
        test_overflow();
        test_width();
        test_random();
        test_handshake();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
